rotary_pos_ctrl: RTL
====================

ROTARY_POS_CTRL -- requirements
Module: rotary_pos_ctrl

Interface
REQ-001 Parameter WIDTH, 3: position counter width in bits, 2..16.
REQ-002 Parameter MIN_VAL, 0: lowest legal position; SHALL satisfy MIN_VAL < MAX_VAL < 2**WIDTH.
REQ-003 Parameter MAX_VAL, 7: highest legal position.
REQ-004 Parameter HOME_VAL, 0: position loaded at reset and on button press; SHALL lie in [MIN_VAL, MAX_VAL].
REQ-005 Parameter STEP_FAST, 2: step size when pmod_sw=1; normal step is always 1; 1 <= STEP_FAST <= MAX_VAL-MIN_VAL.
REQ-006 Parameter WRAP, 1: 1 = modular wrap within [MIN_VAL, MAX_VAL], 0 = saturate at the bounds.
REQ-007 Parameter DEB_CYCLES, 4: consecutive stable cycles required to accept a new button level, >= 1.
REQ-008 clk  input  1  single system clock; all state on rising edge.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 rotary_event  input  1  level from encoder decoder, high while a detent event is reported; synchronous to clk.
REQ-011 rotary_left  input  1  direction of the event: 1 = left (decrement), 0 = right (increment); synchronous to clk.
REQ-012 pmod_sw  input  1  raw slide switch, asynchronous; 1 = fast step.
REQ-013 pmod_btns  input  1  raw push button, asynchronous, active high; 1 = home.
REQ-014 pos  output  WIDTH  current position, registered.
REQ-015 pos_changed  output  1  one-cycle pulse, high in the first cycle pos holds a new value.
REQ-016 at_limit  output  1  registered; high when WRAP=0 and pos equals MIN_VAL or MAX_VAL; constant 0 when WRAP=1.
REQ-017 btn_level  output  1  debounced button level.

Function
REQ-018 pmod_sw and pmod_btns SHALL each pass through a two-flop synchroniser before any use.
REQ-019 Debounce: a counter SHALL count cycles in which the synchronised button differs from btn_level, clear whenever they agree, and on reaching DEB_CYCLES toggle btn_level and clear.
REQ-020 Event detection: a registered copy of rotary_event SHALL be kept; a step is taken only on a rising edge (rotary_event=1, copy=0); a held level produces exactly one step.
REQ-021 Step size = STEP_FAST when synchronised pmod_sw=1, else 1; direction from rotary_left sampled in the rising-edge cycle.
REQ-022 Arithmetic SHALL be done at WIDTH+2 bits with no intermediate overflow.
REQ-023 WRAP=1 increment: result > MAX_VAL yields MIN_VAL + (result - MAX_VAL - 1); decrement: result < MIN_VAL yields MAX_VAL - (MIN_VAL - result - 1).
REQ-024 WRAP=0: result clamps to MAX_VAL on increment, MIN_VAL on decrement.
REQ-025 Latency: pos SHALL update on the clock edge that samples the rising edge of rotary_event (visible one cycle after event rises).
REQ-026 pos_changed SHALL pulse only when the new pos differs from the old; a saturated step at a bound gives no pulse.
REQ-027 Priority: btn_level=1 overrides events; while high, pos is forced to HOME_VAL and all rising edges are discarded (not queued).
REQ-028 Transition of btn_level 0->1 SHALL load HOME_VAL and pulse pos_changed iff pos was not already HOME_VAL.
REQ-029 at_limit SHALL be registered from the new pos value in the same cycle pos updates.

Reset
REQ-030 While reset is high, asynchronously: pos=HOME_VAL, pos_changed=0, btn_level=0, debounce counter=0, synchroniser flops=0, event copy=1 (so an event already high at release is not counted), at_limit per REQ-016 for HOME_VAL.
REQ-031 Reset asserted mid-debounce or mid-event SHALL abandon the operation; no step or home occurs from pre-reset stimulus.

Verification (defaults unless stated)
REQ-032 pos=0, three rising edges with rotary_left=0, pmod_sw=0 -> pos 1,2,3, three pos_changed pulses.
REQ-033 pos=6, pmod_sw=1, one right event -> pos=0 (wrap), pulse; then left event with pmod_sw=1 -> pos=6.
REQ-034 WRAP=0, pos=7, right event fast -> pos=7, no pulse, at_limit=1; left event normal -> pos=6, pulse, at_limit=0.
REQ-035 pos=5, pmod_btns high 3 cycles then low -> no change; held 4+ cycles past synchroniser -> pos=0, one pulse, events during hold ignored.
REQ-036 rotary_event held high 20 cycles -> exactly one step; reset pulsed with rotary_event high -> pos=HOME_VAL, no step after release until event falls and rises again.

Source files
------------

// File: rtl/rotary_pos_ctrl.sv
// Rotary-encoder position register with a fast-step switch, a debounced
// home button, and either modular wrap or saturation at the range bounds.
module rotary_pos_ctrl #(
    parameter int WIDTH      = 3,
    parameter int MIN_VAL    = 0,
    parameter int MAX_VAL    = 7,
    parameter int HOME_VAL   = 0,
    parameter int STEP_FAST  = 2,
    parameter int WRAP       = 1,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rotary_event,
    input  logic             rotary_left,
    input  logic             pmod_sw,
    input  logic             pmod_btns,
    output logic [WIDTH-1:0] pos,
    output logic             pos_changed,
    output logic             at_limit,
    output logic             btn_level
);

    // Two guard bits keep pos+step and MAX+1+pos from overflowing.
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(DEB_CYCLES + 1);

    localparam logic [AW-1:0]    MIN_A  = AW'(MIN_VAL);
    localparam logic [AW-1:0]    MAX_A  = AW'(MAX_VAL);
    localparam logic [AW-1:0]    ONE_A  = AW'(1);
    localparam logic [AW-1:0]    FAST_A = AW'(STEP_FAST);
    localparam logic [WIDTH-1:0] MIN_P  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_P  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] HOME_P = WIDTH'(HOME_VAL);
    localparam logic             LIM_HOME = (WRAP == 0) &&
                                            (HOME_VAL == MIN_VAL || HOME_VAL == MAX_VAL);

    logic [1:0]       sw_sync, btn_sync;
    logic             sw_s, btn_s;
    logic [CW-1:0]    deb_cnt, deb_cnt_nxt;
    logic             btn_nxt;
    logic             evt_q, rise;
    logic [AW-1:0]    pos_a, step_a, sum_a;
    logic [WIDTH-1:0] step_res, pos_nxt;

    assign sw_s  = sw_sync[1];
    assign btn_s = btn_sync[1];
    assign rise  = rotary_event & ~evt_q;

    // Two-flop synchronisers for the asynchronous switch and button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_sync  <= 2'b00;
            btn_sync <= 2'b00;
        end else begin
            sw_sync  <= {sw_sync[0], pmod_sw};
            btn_sync <= {btn_sync[0], pmod_btns};
        end
    end

    // Debounce: count consecutive disagreeing cycles, flip level at DEB_CYCLES.
    always_comb begin
        btn_nxt     = btn_level;
        deb_cnt_nxt = '0;
        if (btn_s != btn_level) begin
            if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
                btn_nxt = ~btn_level;
            end else begin
                deb_cnt_nxt = deb_cnt + CW'(1);
            end
        end
    end

    // Debounce state and event edge copy; copy resets high so a held event is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_cnt   <= '0;
            btn_level <= 1'b0;
            evt_q     <= 1'b1;
        end else begin
            deb_cnt   <= deb_cnt_nxt;
            btn_level <= btn_nxt;
            evt_q     <= rotary_event;
        end
    end

    // Next position: home has priority, otherwise a wrapped or clamped step on a rising edge.
    always_comb begin
        pos_a    = {2'b00, pos};
        step_a   = sw_s ? FAST_A : ONE_A;
        sum_a    = pos_a + step_a;
        step_res = pos;
        if (!rotary_left) begin
            if (sum_a > MAX_A) begin
                step_res = (WRAP != 0) ? WIDTH'(MIN_A + (sum_a - MAX_A - ONE_A)) : MAX_P;
            end else begin
                step_res = WIDTH'(sum_a);
            end
        end else begin
            if (pos_a < MIN_A + step_a) begin
                step_res = (WRAP != 0) ? WIDTH'((MAX_A + ONE_A + pos_a) - (MIN_A + step_a)) : MIN_P;
            end else begin
                step_res = WIDTH'(pos_a - step_a);
            end
        end

        pos_nxt = pos;
        if (btn_nxt) begin
            pos_nxt = HOME_P;
        end else if (rise) begin
            pos_nxt = step_res;
        end
    end

    // Position, change pulse and limit flag all register from the same next value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos         <= HOME_P;
            pos_changed <= 1'b0;
            at_limit    <= LIM_HOME;
        end else begin
            pos         <= pos_nxt;
            pos_changed <= (pos_nxt != pos);
            at_limit    <= (WRAP == 0) && (pos_nxt == MIN_P || pos_nxt == MAX_P);
        end
    end

endmodule
